// File: rtl/imem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_ctrl_pkg
// Description : Shared types and constants for the instruction-fetch
//               controller: FSM state encoding, fetch-queue entry layout,
//               instruction width and the ebreak opcode that halts fetch.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_ctrl_pkg;

  localparam int INSTR_W = 32;

  // ebreak: fetching this word stops the controller
  localparam logic [INSTR_W-1:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Shift-register FIFO of {pc, instr} entries. Entry 0 is the
//               head, so the head outputs come straight from flops and read
//               as zero whenever the queue is empty.
// Ports       : clk, rst        - clock, async active-high reset
//               flush           - drop all entries (wins over push/pop)
//               push/push_entry - enqueue (accepted if not full or popping)
//               pop             - dequeue head (ignored when empty)
//               head            - current head entry (0 when empty)
//               count           - number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import imem_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fq_entry_t        push_entry,
  input  logic             pop,
  output fq_entry_t        head,
  output logic [CNT_W-1:0] count
);

  fq_entry_t [DEPTH-1:0] ent;
  fq_entry_t [DEPTH-1:0] ent_shifted;
  logic [CNT_W-1:0]      cnt;
  logic                  pop_ok;
  logic                  push_ok;
  logic [CNT_W-1:0]      wr_idx;

  // Shifting down one entry fills the top slot with zeros, which keeps
  // unused slots (and therefore an empty head) at zero.
  assign ent_shifted = ent >> $bits(fq_entry_t);

  assign pop_ok  = pop & (cnt != '0);
  assign push_ok = push & ((cnt != CNT_W'(DEPTH)) | pop_ok);
  // A simultaneous pop moves every entry down, so the write lands one lower.
  assign wr_idx  = cnt - CNT_W'(pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent <= '0;
      cnt <= '0;
    end else if (flush) begin
      ent <= '0;
      cnt <= '0;
    end else begin
      if (pop_ok) begin
        ent <= ent_shifted;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok && (wr_idx == CNT_W'(i))) begin
          ent[i] <= push_entry;
        end
      end
      cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  assign head  = ent[0];
  assign count = cnt;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_ctrl
// Description : Instruction-fetch controller. Owns the PC, fetches one word
//               per cycle into a small fetch queue feeding ID, handles
//               redirects and halts after fetching ebreak. Optionally lets a
//               boot loader write instruction memory before RUN.
// Config      : IMEM_LOADER_EN - when defined, adds the LOAD state, the ld_*
//               ports and the memory write mux. When undefined, IDLE goes
//               straight to RUN and imem_we/imem_wdata are tied to 0.
// Ports       : clk, rst (async active-high), start
//               imem_addr/imem_rdata/imem_we/imem_wdata - memory port
//               ld_valid/ld_addr/ld_data/ld_ready/ld_done - loader (optional)
//               redirect_valid/redirect_pc - flush and restart fetch
//               id_valid/id_ready/id_instr/id_pc - queue head to ID
//               halted, state - status
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2              // legal: 2 or 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_we,
  output logic [INSTR_W-1:0] imem_wdata,
`ifdef IMEM_LOADER_EN
  input  logic               ld_valid,
  input  logic [31:0]        ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ld_ready,
  input  logic               ld_done,
`endif
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic               halted,
  output logic [1:0]         state
);

  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  state_t           st;
  logic [31:0]      pc;
  fq_entry_t        fq_head;
  fq_entry_t        fq_push_entry;
  logic [CNT_W-1:0] fq_count;
  logic             fq_full;
  logic             pop;
  logic             fetch;
  logic             flush;
  logic             unused_rpc_lsbs;

  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  assign fq_full = (fq_count == CNT_W'(FQ_DEPTH));
  assign pop     = id_valid & id_ready;
  assign flush   = (st == ST_RUN) & redirect_valid;
  // A full queue can still take a word when its head leaves this cycle.
  assign fetch   = (st == ST_RUN) & ~redirect_valid & (~fq_full | pop);

  assign fq_push_entry = '{pc: pc, instr: imem_rdata};

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (fetch),
    .push_entry (fq_push_entry),
    .pop        (pop),
    .head       (fq_head),
    .count      (fq_count)
  );

  assign id_valid = (fq_count != '0);
  assign id_instr = fq_head.instr;
  assign id_pc    = fq_head.pc;
  assign state    = st;

  // Memory port mux: the loader owns the port only while in LOAD.
  always_comb begin
    imem_addr  = pc;
    imem_we    = 1'b0;
    imem_wdata = '0;
`ifdef IMEM_LOADER_EN
    if (st == ST_LOAD) begin
      imem_addr  = ld_addr;
      imem_we    = ld_valid;
      imem_wdata = ld_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= ST_IDLE;
      pc     <= RESET_PC;
      halted <= 1'b0;
`ifdef IMEM_LOADER_EN
      ld_ready <= 1'b0;
`endif
    end else begin
      case (st)
        ST_IDLE: begin
          if (start) begin
`ifdef IMEM_LOADER_EN
            st       <= ST_LOAD;
            ld_ready <= 1'b1;
`else
            st       <= ST_RUN;
`endif
            pc <= RESET_PC;
          end
        end
`ifdef IMEM_LOADER_EN
        ST_LOAD: begin
          if (ld_done) begin
            st       <= ST_RUN;
            ld_ready <= 1'b0;
            pc       <= RESET_PC;
          end
        end
`endif
        ST_RUN: begin
          if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
          end else if (fetch) begin
            pc <= pc + 32'd4;
            // ebreak is still pushed to the queue; fetching stops after it
            if (imem_rdata == EBREAK_INSTR) begin
              st     <= ST_HALT;
              halted <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          st <= ST_HALT;
        end
        default: begin
          st <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_ctrl
// Description : Self-checking bench for imem_fetch_ctrl. Models the
//               instruction memory, checks ID deliveries against an expected
//               stream queue, and walks a redirect vector table.
//               Builds with or without IMEM_LOADER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;
  import imem_ctrl_pkg::*;

  localparam int          FQ_DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_we;
  logic [31:0] imem_wdata;
`ifdef IMEM_LOADER_EN
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
`endif
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;
  logic [1:0]  state;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_we        (imem_we),
    .imem_wdata     (imem_wdata),
`ifdef IMEM_LOADER_EN
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .ld_done        (ld_done),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .halted         (halted),
    .state          (state)
  );

  // 64-word instruction memory, combinational read, synchronous write
  logic [31:0] mem [64];
  assign imem_rdata = mem[imem_addr[7:2]];
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr[7:2]] <= imem_wdata;
  end

  function automatic logic [31:0] pat(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs settle well
  // before the following falling edge where the monitor samples.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected ID stream
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;
  logic mon_en = 1'b0;
  int   ndeliv = 0;

  always @(negedge clk) begin
    if (mon_en && !rst && id_valid && id_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual_pc=%h actual_instr=%h required=none", id_pc, id_instr);
      end else begin
        m_e = sb.pop_front();
        check("pop_pc", id_pc, m_e.pc);
        check("pop_instr", id_instr, m_e.instr);
      end
      ndeliv++;
    end
  end

  // Redirect vectors: input target, expected fetch address in N+1, expected
  // head in N+2 and the fetch address following it (with wrap).
  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_fetch;
    logic [31:0] exp_id_pc;
    logic [31:0] exp_id_instr;
    logic [31:0] exp_next;
  } rd_vec_t;
  rd_vec_t rd_tab[4];

  initial begin
    int budget;
    int rem;

    rd_tab[0] = '{32'h0000_0012, 32'h0000_0010, 32'h0000_0010, 32'hA000_0004, 32'h0000_0014};
    rd_tab[1] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_0040, 32'hA000_0010, 32'h0000_0044};
    rd_tab[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hA000_003F, 32'h0000_0000};
    rd_tab[3] = '{32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 32'hA000_0000, 32'h0000_0004};

    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
`ifdef IMEM_LOADER_EN
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
`endif
    for (int i = 0; i < 64; i++) mem[i] = pat(i);

    // ---- reset state ----
    repeat (2) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
`ifdef IMEM_LOADER_EN
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("idle_state", 32'(state), 32'd0);

    // ---- load / start, then streamed fetch with a stall ----
    for (int i = 0; i < 12; i++) begin
      m_e.pc    = 32'(4 * i);
      m_e.instr = (i == 1) ? 32'h0050_0293 : pat(i);
      sb.push_back(m_e);
    end
    ndeliv = 0; mon_en = 1'b1; id_ready = 1'b1;
`ifdef IMEM_LOADER_EN
    start = 1'b1; tick(); start = 1'b0;
    check("load_state", 32'(state), 32'd1);
    check("load_ready", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1; ld_addr = 32'h4; ld_data = 32'h0050_0293; ld_done = 1'b1;
    #1;
    check("load_we", 32'(imem_we), 32'd1);
    check("load_addr", imem_addr, 32'h4);
    check("load_wdata", imem_wdata, 32'h0050_0293);
    tick();
    ld_valid = 1'b0; ld_done = 1'b0; ld_addr = '0; ld_data = '0;
    check("load_written", mem[1], 32'h0050_0293);
    check("load_ready_off", 32'(ld_ready), 32'd0);
`else
    mem[1] = 32'h0050_0293;
    start = 1'b1; tick(); start = 1'b0;
`endif
    check("run_state", 32'(state), 32'd2);
    check("run_first_addr", imem_addr, 32'h0);
    check("run_no_valid_yet", 32'(id_valid), 32'd0);
    tick();
    check("lat_valid", 32'(id_valid), 32'd1);
    check("lat_id_pc", id_pc, 32'h0);
    check("lat_addr", imem_addr, 32'h4);
    tick();
    check("second_pc", id_pc, 32'h4);
    check("second_instr", id_instr, 32'h0050_0293);
    id_ready = 1'b0;
    repeat (5) tick();
    check("stall_valid", 32'(id_valid), 32'd1);
    check("stall_pc_frozen", imem_addr, 32'(4 * (ndeliv + FQ_DEPTH)));
    tick();
    check("stall_pc_frozen2", imem_addr, 32'(4 * (ndeliv + FQ_DEPTH)));
    rem = sb.size();
    id_ready = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      tick();
      budget++;
    end
    id_ready = 1'b0;
    check("stream_drained", 32'(sb.size()), 32'd0);
    check("throughput_cycles", 32'(budget), 32'(rem));
    mon_en = 1'b0;

    // ---- redirect vectors (queue full and popping at redirect) ----
    for (int v = 0; v < 4; v++) begin
      id_ready = 1'b0;
      repeat (FQ_DEPTH + 1) tick();
      check("rd_full_valid", 32'(id_valid), 32'd1);
      id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = rd_tab[v].rpc;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("rd_fetch_addr", imem_addr, rd_tab[v].exp_fetch);
      check("rd_flushed", 32'(id_valid), 32'd0);
      tick();
      check("rd_valid", 32'(id_valid), 32'd1);
      check("rd_id_pc", id_pc, rd_tab[v].exp_id_pc);
      check("rd_id_instr", id_instr, rd_tab[v].exp_id_instr);
      check("rd_next_addr", imem_addr, rd_tab[v].exp_next);
    end

    // ---- ebreak halt ----
    mem[34] = EBREAK_INSTR;
    m_e = '{pc: 32'h80, instr: 32'hA000_0020}; sb.push_back(m_e);
    m_e = '{pc: 32'h84, instr: 32'hA000_0021}; sb.push_back(m_e);
    m_e = '{pc: 32'h88, instr: 32'h0010_0073}; sb.push_back(m_e);
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0; mon_en = 1'b1; id_ready = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 30) begin
      tick();
      budget++;
    end
    check("halt_drained", 32'(sb.size()), 32'd0);
    check("halt_state", 32'(state), 32'd3);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", imem_addr, 32'h8C);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    check("halt_rd_state", 32'(state), 32'd3);
    check("halt_rd_pc", imem_addr, 32'h8C);
    check("halt_empty", 32'(id_valid), 32'd0);
    mon_en = 1'b0;
    mem[34] = pat(34);

    // ---- reset mid-operation ----
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("rerst_state", 32'(state), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
`ifdef IMEM_LOADER_EN
    check("mid_load_state", 32'(state), 32'd1);
    ld_valid = 1'b1; ld_addr = 32'h8; ld_data = 32'hDEAD_BEEF;
    #1;
    check("mid_load_we", 32'(imem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_load_rst_we", 32'(imem_we), 32'd0);
    check("mid_load_rst_state", 32'(state), 32'd0);
    check("mid_load_rst_valid", 32'(id_valid), 32'd0);
    check("mid_load_rst_ready", 32'(ld_ready), 32'd0);
    tick();
    check("mid_load_dropped", mem[2], pat(2));
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    rst = 1'b0;
`else
    id_ready = 1'b0;
    repeat (3) tick();
    check("mid_run_valid", 32'(id_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_run_rst_state", 32'(state), 32'd0);
    check("mid_run_rst_valid", 32'(id_valid), 32'd0);
    check("mid_run_rst_id_pc", id_pc, 32'd0);
    check("mid_run_rst_addr", imem_addr, RESET_PC);
    tick();
    rst = 1'b0;
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
